// File: rtl/apb_arbiter2.sv
// Two-master, one-completer APB arbiter with round-robin tie-break.
// The grant is held for one full downstream transfer (SETUP, ACCESS, wait states).
module apb_arbiter2 #(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RESETn,
    input  logic                  M0_PSEL,
    input  logic                  M0_PENABLE,
    input  logic [ADDR_WIDTH-1:0] M0_PADDR,
    input  logic                  M0_PWRITE,
    input  logic [DATA_WIDTH-1:0] M0_PWDATA,
    output logic [DATA_WIDTH-1:0] M0_PRDATA,
    output logic                  M0_PREADY,
    input  logic                  M1_PSEL,
    input  logic                  M1_PENABLE,
    input  logic [ADDR_WIDTH-1:0] M1_PADDR,
    input  logic                  M1_PWRITE,
    input  logic [DATA_WIDTH-1:0] M1_PWDATA,
    output logic [DATA_WIDTH-1:0] M1_PRDATA,
    output logic                  M1_PREADY,
    output logic                  PSEL,
    output logic                  PENABLE,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    output logic [1:0]            GRANT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t     state;
    logic [1:0] grant;
    logic       last;

    // Masters' PENABLE carries no arbitration information.
    logic unused_penable;
    assign unused_penable = M0_PENABLE ^ M1_PENABLE;

    // Arbitration FSM; `last` only matters when both masters request at once.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state <= ST_IDLE;
            grant <= 2'b00;
            last  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (M0_PSEL && M1_PSEL) begin
                        grant <= last ? 2'b01 : 2'b10;
                        state <= ST_SETUP;
                    end else if (M0_PSEL) begin
                        grant <= 2'b01;
                        state <= ST_SETUP;
                    end else if (M1_PSEL) begin
                        grant <= 2'b10;
                        state <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (PREADY) begin
                        state <= ST_IDLE;
                        last  <= grant[1];
                        grant <= 2'b00;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    // Downstream request follows the live inputs of the granted master.
    always_comb begin
        PADDR  = '0;
        PWRITE = 1'b0;
        PWDATA = '0;
        if (state != ST_IDLE) begin
            if (grant[0]) begin
                PADDR  = M0_PADDR;
                PWRITE = M0_PWRITE;
                PWDATA = M0_PWDATA;
            end else if (grant[1]) begin
                PADDR  = M1_PADDR;
                PWRITE = M1_PWRITE;
                PWDATA = M1_PWDATA;
            end
        end
    end

    assign PSEL    = (state != ST_IDLE);
    assign PENABLE = (state == ST_ACCESS);
    assign GRANT   = grant;

    assign M0_PREADY = grant[0] && (state == ST_ACCESS) && PREADY;
    assign M1_PREADY = grant[1] && (state == ST_ACCESS) && PREADY;
    assign M0_PRDATA = grant[0] ? PRDATA : '0;
    assign M1_PRDATA = grant[1] ? PRDATA : '0;

endmodule
